adder_16b_arb: RTL
==================

// Module: adder_16b_arb
// PURPOSE
// - Shares one adder_16b instance (instantiated internally) among NREQ requesters.
// - Round-robin arbitration with a valid/ready handshake on every request port.
// - Single-entry registered response carrying requester id, sum and carry-out.
// - Sits between client datapath blocks and the adder; owns all sequencing of the adder.
// PARAMETERS
// - NREQ   4   number of requesters, 2..16
// - WIDTH  16  operand width; fixed to 16 to match adder_16b, any other value is an elaboration error
// - IDW    $clog2(NREQ)  derived localparam, width of rsp_id
// PORTS
// - clk        in   1           rising-edge clock
// - rst_n      in   1           asynchronous active-low reset
// - req_valid  in   NREQ        request i valid
// - req_ready  out  NREQ        request i accepted this cycle; one-hot or zero
// - req_a      in   NREQ*WIDTH  operand A; slice i = [i*WIDTH +: WIDTH]
// - req_b      in   NREQ*WIDTH  operand B, same packing as req_a
// - req_cin    in   NREQ        carry-in per requester
// - rsp_valid  out  1           response register holds a result
// - rsp_ready  in   1           consumer accepts the response
// - rsp_id     out  IDW         index of the requester that produced the result
// - rsp_sum    out  WIDTH       A+B+Cin mod 2^16
// - rsp_co     out  1           carry-out of the 16-bit add
// - rsp_ovf    out  1           signed overflow; port present only with ADDER_ARB_OVF_EN
// BEHAVIOUR
// - Reset (async, rst_n=0): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_co=0, rsp_ovf=0, rr_ptr=0, state=IDLE. req_ready=0 while in reset.
// - A pending response is discarded on reset; no request is accepted during reset.
// - Two-state FSM:
//   - IDLE: rsp_valid=0. Goes to FULL when a request is accepted.
//   - FULL: rsp_valid=1.
//     - Goes to IDLE on rsp_ready when no request is accepted in the same cycle.
//     - Stays in FULL when it drains and accepts a new request in the same cycle.
// - can_accept = (state==IDLE) | rsp_ready.
// - Grant is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NREQ-1 -> 0. Combinational, same cycle.
// - req_ready[i] = grant[i] & can_accept. At most one bit is set. No grant when req_valid==0.
// - On acceptance (req_valid[i] & req_ready[i]):
//   - Next edge loads rsp_id=i and the adder outputs for slice i into the response register.
//   - rr_ptr = (i+1) mod NREQ.
// - rr_ptr is unchanged when nothing is accepted. A stall therefore does not rotate priority.
// - Latency: result is valid 1 cycle after acceptance. Throughput is 1 per cycle when rsp_ready is held high.
// - Response stability: while rsp_valid=1 and rsp_ready=0, rsp_* hold their values.
// - Requesters hold req_valid and operands until req_ready. Dropping req_valid early is legal and simply withdraws the request.
// - Arithmetic: {rsp_co,rsp_sum} = A + B + Cin as a 17-bit unsigned result.
//   - FFFF+FFFF+1 -> co=1, sum=FFFF.
// CONFIGURATION
// - ADDER_ARB_OVF_EN defined:
//   - rsp_ovf port exists.
//   - rsp_ovf = (A[15]==B[15]) & (sum[15]!=A[15]), registered together with rsp_sum.
// - ADDER_ARB_OVF_EN undefined: no rsp_ovf port and no overflow logic. All other behaviour is identical.
// TESTING
// - Reset: assert rst_n=0 mid-FULL -> rsp_valid=0, rsp_sum=0, rr_ptr=0 immediately, without waiting for a clock edge.
// - Single requester: req0 8FFF+8000 cin0, rsp_ready=1
//   -> next cycle rsp_valid=1, id=0, sum=0FFF, co=1.
// - Carry paths:
//   - FFFE+0002 cin0 -> sum=0000, co=1.
//   - AAAA+5555 cin0 -> sum=FFFF, co=0.
//   - AAAA+5555 cin1 -> sum=0000, co=1.
// - Round-robin: all 4 req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, one per cycle.
// - Backpressure: rsp_ready=0 for 3 cycles with result pending
//   -> rsp_* stable, req_ready=0, rr_ptr unchanged.
//   - Then rsp_ready=1 -> drain and accept the next request in the same cycle.
// - Overflow (ADDER_ARB_OVF_EN defined):
//   - 7FFF+0001 -> ovf=1, co=0.
//   - 8000+8000 -> ovf=1, co=1, sum=0000.

Source files
------------

// File: rtl/adder_16b_arb.sv
// -----------------------------------------------------------------------------
// adder_16b_arb
//   Shares one 16-bit adder (adder_16b, defined below) among NREQ requesters.
//   A round-robin arbiter picks one valid request per cycle. The chosen
//   operands go through the adder, and the result is loaded into a
//   single-entry response register. That register drains through a
//   valid/ready handshake.
//
//   Optional feature macro: ADDER_ARB_OVF_EN adds the rsp_ovf port and the
//   signed-overflow flag.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        request valid per requester
//   req_ready  out  [NREQ]        request accepted this cycle (one-hot or zero)
//   req_a      in   [NREQ*WIDTH]  operand A, slice i = [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]  operand B, same packing
//   req_cin    in   [NREQ]        carry-in per requester
//   rsp_valid  out  response register holds a result
//   rsp_ready  in   consumer accepts the response
//   rsp_id     out  [IDW]         requester index of the held result
//   rsp_sum    out  [WIDTH]       A+B+Cin mod 2^16
//   rsp_co     out  carry-out of the add
//   rsp_ovf    out  signed overflow (only with ADDER_ARB_OVF_EN)
// -----------------------------------------------------------------------------

// Plain 16-bit adder with carry-in and carry-out.
module adder_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        co_o
);
  assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {16'd0, cin_i};
endmodule

module adder_16b_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  input  logic [NREQ-1:0]           req_cin,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic                      rsp_co
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                      rsp_ovf
`endif
);

  localparam int IDW = $clog2(NREQ);

  if (WIDTH != 16) begin : g_width_chk
    $error("adder_16b_arb: WIDTH must be 16");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_nreq_chk
    $error("adder_16b_arb: NREQ must be in 2..16");
  end

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_co_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             can_accept;
  logic             accept;
  logic [15:0]      a_sel, b_sel, add_sum;
  logic             cin_sel, add_co;

  // Index p advanced by k positions, wrapping at NREQ (NREQ need not be a power of 2).
  function automatic logic [IDW-1:0] ptr_plus(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return s[IDW-1:0];
  endfunction

  // Round-robin search: first valid request starting at rr_ptr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[ptr_plus(rr_ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ptr_plus(rr_ptr_q, k);
      end
    end
  end

  // A request can land when the slot is empty or is being drained this cycle;
  // rst_n gating keeps req_ready low throughout reset.
  assign can_accept = (state_q == IDLE) | rsp_ready;
  assign accept     = gnt_found & can_accept & rst_n;

  // One-hot ready to the granted requester only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && (gnt_idx == i[IDW-1:0])) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Operand mux feeding the shared adder.
  assign a_sel   = req_a[gnt_idx*WIDTH +: 16];
  assign b_sel   = req_b[gnt_idx*WIDTH +: 16];
  assign cin_sel = req_cin[gnt_idx];

  adder_16b u_adder (
    .a_i   (a_sel),
    .b_i   (b_sel),
    .cin_i (cin_sel),
    .sum_o (add_sum),
    .co_o  (add_co)
  );

  // Next-state logic for the response slot and the priority pointer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FULL;
        end else begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Priority only rotates on an actual acceptance, so stalls keep the order.
    if (accept) begin
      rr_ptr_d = ptr_plus(gnt_idx, 1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Response register: loads only on acceptance, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_co_q  <= 1'b0;
    end else if (accept) begin
      rsp_id_q  <= gnt_idx;
      rsp_sum_q <= add_sum;
      rsp_co_q  <= add_co;
    end else begin
      rsp_id_q  <= rsp_id_q;
      rsp_sum_q <= rsp_sum_q;
      rsp_co_q  <= rsp_co_q;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_co    = rsp_co_q;

`ifdef ADDER_ARB_OVF_EN
  logic ovf_calc;
  logic rsp_ovf_q;

  // Signed overflow: operands agree in sign but the result's sign differs.
  assign ovf_calc = (a_sel[15] == b_sel[15]) & (add_sum[15] != a_sel[15]);

  // Overflow flag registered alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf_q <= 1'b0;
    end else if (accept) begin
      rsp_ovf_q <= ovf_calc;
    end else begin
      rsp_ovf_q <= rsp_ovf_q;
    end
  end

  assign rsp_ovf = rsp_ovf_q;
`endif

endmodule
